x_detect_select: RTL and testbench

Downstream consumer of `x_calculate`. It takes one equalised candidate (xI1, xQ1, xI2, xQ2, Q8.8) per `q_done` pulse and hard-slices each component to the 16-QAM grid {±1, ±3}. It computes a squared slicing-error metric and tracks the minimum over NUM_Q candidates per frame. When the frame completes it emits the winning q index plus its Gray-mapped bits.

---
 rtl/xsel_pkg.sv | 32 +++
 rtl/x_detect_select_slicer.sv | 46 ++++
 rtl/x_detect_select.sv | 223 ++++++++++++++++++++++
 tb/tb_x_detect_select.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xsel_pkg.sv
// Shared definitions for the x_detect_select slice: Q8.8 grid levels,
// Gray mapping, FSM state type and metric-width helper.
package xsel_pkg;

  // 16-QAM grid levels and decision threshold in Q8.8
  localparam int XSEL_Q88_ONE    = 256;
  localparam int XSEL_Q88_THREE  = 768;
  localparam int XSEL_Q88_THRESH = 512;

  // Gray code per decision region, region 0 (-3) in the low pair up to region 3 (+3)
  localparam logic [7:0] XSEL_GRAY_LUT = 8'b10_11_01_00;

  // Pipeline stages still in flight after the last candidate enters S1
  localparam int unsigned XSEL_FLUSH_CYC = 3;

  typedef enum logic [1:0] {
    XSEL_IDLE,
    XSEL_COLLECT,
    XSEL_FLUSH,
    XSEL_DONE
  } xsel_state_t;

  function automatic int unsigned xsel_met_w(input int unsigned n);
    return 2 * n + 4;
  endfunction

  // Fixed-point constant mult * 2^q
  function automatic int xsel_fix(input int unsigned q, input int mult);
    return mult * (1 << q);
  endfunction

endpackage

// File: rtl/x_detect_select_slicer.sv
// xsel_slicer: hard-slices one component to {-3,-1,+1,+3}, returns the
// Gray bits of the decision and the signed slicing error x - level.
module xsel_slicer
  import xsel_pkg::*;
#(
  parameter int unsigned N         = 16,
  parameter int          LVL_ONE   = XSEL_Q88_ONE,
  parameter int          LVL_THREE = XSEL_Q88_THREE,
  parameter int          THRESH    = XSEL_Q88_THRESH
) (
  input  logic signed [N-1:0] x_i,
  output logic        [1:0]   gray_o,
  output logic signed [N:0]   err_o
);

  localparam logic signed [N-1:0] POS1  = N'(LVL_ONE);
  localparam logic signed [N-1:0] NEG1  = N'(-LVL_ONE);
  localparam logic signed [N-1:0] POS3  = N'(LVL_THREE);
  localparam logic signed [N-1:0] NEG3  = N'(-LVL_THREE);
  localparam logic signed [N-1:0] POS_T = N'(THRESH);
  localparam logic signed [N-1:0] NEG_T = N'(-THRESH);

  logic        [1:0]   region;
  logic signed [N-1:0] lvl;

  // Decision region and reconstruction level
  always_comb begin
    if (x_i < NEG_T) begin
      region = 2'd0;
      lvl    = NEG3;
    end else if (x_i[N-1]) begin
      region = 2'd1;
      lvl    = NEG1;
    end else if (x_i < POS_T) begin
      region = 2'd2;
      lvl    = POS1;
    end else begin
      region = 2'd3;
      lvl    = POS3;
    end
  end

  assign gray_o = XSEL_GRAY_LUT[{region, 1'b0} +: 2];
  assign err_o  = {x_i[N-1], x_i} - {lvl[N-1], lvl};

endmodule

// File: rtl/x_detect_select.sv
// x_detect_select: slices each candidate to the 16-QAM grid, computes the
// squared slicing error and reports the lowest-metric candidate per frame.
// Optional macro XSEL_METRIC_OUT_EN adds the det_metric output.
module x_detect_select
  import xsel_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned Q     = 8,
  parameter int unsigned NUM_Q = 16,
  parameter int unsigned QW    = 4,
  parameter int unsigned MET_W = xsel_met_w(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_frame,
  input  logic                q_valid,
  input  logic [QW-1:0]       q_index,
  input  logic signed [N-1:0] xI1_in,
  input  logic signed [N-1:0] xQ1_in,
  input  logic signed [N-1:0] xI2_in,
  input  logic signed [N-1:0] xQ2_in,
  output logic                busy,
  output logic                det_valid,
  output logic [QW-1:0]       det_q,
  output logic [7:0]          det_bits,
`ifdef XSEL_METRIC_OUT_EN
  output logic [MET_W-1:0]    det_metric,
`endif
  output logic                ovf
);

  localparam int unsigned CW  = $clog2(NUM_Q + 1);
  localparam int unsigned SQW = 2 * N + 2;

  xsel_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_base;
  logic [1:0]    flush_q, flush_d;
  logic          ovf_q, ovf_d;
  logic          accept;
  logic          det_valid_d;

  logic signed [N-1:0] xin [4];
  logic        [1:0]   gray [4];
  logic signed [N:0]   err [4];

  logic                s1_v_q, s2_v_q, s3_v_q;
  logic [QW-1:0]       s1_q_q, s2_q_q, s3_q_q;
  logic [7:0]          s1_bits_q, s2_bits_q, s3_bits_q;
  logic signed [N:0]   s1_e_q [4];
  logic [SQW-1:0]      sq_d [4];
  logic [SQW-1:0]      s2_sq_q [4];
  logic [MET_W-1:0]    met_d, s3_met_q;
  logic signed [SQW-1:0] ext;

  logic [MET_W-1:0]    best_met_q;
  logic [QW-1:0]       best_q_q;
  logic [7:0]          best_bits_q;

  logic                det_valid_q;
  logic [QW-1:0]       det_q_q;
  logic [7:0]          det_bits_q;

  // A start pulse opens the frame in the same cycle, so its candidate counts
  assign accept = q_valid && (start_frame || state_q == XSEL_COLLECT);

  assign xin[0] = xI1_in;
  assign xin[1] = xQ1_in;
  assign xin[2] = xI2_in;
  assign xin[3] = xQ2_in;

  for (genvar k = 0; k < 4; k++) begin : g_slice
    xsel_slicer #(
      .N         (N),
      .LVL_ONE   (xsel_fix(Q, 1)),
      .LVL_THREE (xsel_fix(Q, 3)),
      .THRESH    (xsel_fix(Q, 2))
    ) u_slicer (
      .x_i    (xin[k]),
      .gray_o (gray[k]),
      .err_o  (err[k])
    );
  end

  // State, candidate count, flush timer and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= XSEL_IDLE;
      cnt_q   <= '0;
      flush_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: start_frame overrides every state
  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    cnt_base = start_frame ? '0 : cnt_q;
    cnt_d    = cnt_base + CW'(accept);
    ovf_d    = start_frame ? 1'b0 : ovf_q;
    if (start_frame || state_q == XSEL_COLLECT) begin
      state_d = (cnt_d == CW'(NUM_Q)) ? XSEL_FLUSH : XSEL_COLLECT;
      flush_d = '0;
    end else begin
      case (state_q)
        XSEL_FLUSH: begin
          if (q_valid) ovf_d = 1'b1;
          if (flush_q == 2'(XSEL_FLUSH_CYC - 1)) state_d = XSEL_DONE;
          else                                   flush_d = flush_q + 2'd1;
        end
        XSEL_DONE: begin
          if (q_valid) ovf_d = 1'b1;
          state_d = XSEL_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    busy        = (state_q == XSEL_COLLECT) || (state_q == XSEL_FLUSH);
    det_valid_d = (state_q == XSEL_DONE);
  end

  // S2 squares of the sign-extended errors
  always_comb begin
    ext  = '0;
    sq_d = '{default: '0};
    for (int unsigned k = 0; k < 4; k++) begin
      ext     = {{(N + 1){s1_e_q[k][N]}}, s1_e_q[k]};
      sq_d[k] = ext * ext;
    end
  end

  // S3 sum of the four squares
  always_comb begin
    met_d = '0;
    for (int unsigned k = 0; k < 4; k++) met_d = met_d + MET_W'(s2_sq_q[k]);
  end

  // S1..S3 pipeline registers; start_frame squashes entries already in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0; s2_v_q <= 1'b0; s3_v_q <= 1'b0;
      s1_q_q <= '0;   s2_q_q <= '0;   s3_q_q <= '0;
      s1_bits_q <= '0; s2_bits_q <= '0; s3_bits_q <= '0;
      s3_met_q  <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        s1_e_q[k]  <= '0;
        s2_sq_q[k] <= '0;
      end
    end else begin
      s1_v_q    <= accept;
      s1_q_q    <= q_index;
      s1_bits_q <= {gray[0], gray[1], gray[2], gray[3]};
      for (int unsigned k = 0; k < 4; k++) begin
        s1_e_q[k]  <= err[k];
        s2_sq_q[k] <= sq_d[k];
      end
      s2_v_q    <= s1_v_q && !start_frame;
      s2_q_q    <= s1_q_q;
      s2_bits_q <= s1_bits_q;
      s3_v_q    <= s2_v_q && !start_frame;
      s3_q_q    <= s2_q_q;
      s3_bits_q <= s2_bits_q;
      s3_met_q  <= met_d;
    end
  end

  // S4 best tracker: strict less-than keeps the earliest of equal metrics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_met_q  <= '1;
      best_q_q    <= '0;
      best_bits_q <= '0;
    end else if (start_frame) begin
      best_met_q  <= '1;
    end else if (s3_v_q && (s3_met_q < best_met_q)) begin
      best_met_q  <= s3_met_q;
      best_q_q    <= s3_q_q;
      best_bits_q <= s3_bits_q;
    end
  end

  // Result registers, loaded on the DONE cycle and held until the next result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_valid_q <= 1'b0;
      det_q_q     <= '0;
      det_bits_q  <= '0;
    end else begin
      det_valid_q <= det_valid_d;
      if (det_valid_d) begin
        det_q_q    <= best_q_q;
        det_bits_q <= best_bits_q;
      end
    end
  end

`ifdef XSEL_METRIC_OUT_EN
  logic [MET_W-1:0] det_met_q;

  // Winning metric, registered alongside det_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           det_met_q <= '0;
    else if (det_valid_d) det_met_q <= best_met_q;
  end

  assign det_metric = det_met_q;
`endif

  assign det_valid = det_valid_q;
  assign det_q     = det_q_q;
  assign det_bits  = det_bits_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_x_detect_select.sv
// Randomized self-checking bench for x_detect_select against a frame-level model.
module tb_x_detect_select;

  localparam int N     = 16;
  localparam int NUM_Q = 16;
  localparam int QW    = 4;
  localparam int MET_W = 2 * N + 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_frame, q_valid;
  logic [QW-1:0] q_index;
  logic [N-1:0]  xI1_in, xQ1_in, xI2_in, xQ2_in;
  logic          busy, det_valid, ovf;
  logic [QW-1:0] det_q;
  logic [7:0]    det_bits;
`ifdef XSEL_METRIC_OUT_EN
  logic [MET_W-1:0] det_metric;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0]  cx [NUM_Q][4];
  logic [QW-1:0] cq [NUM_Q];

  x_detect_select #(
    .N(N), .Q(8), .NUM_Q(NUM_Q), .QW(QW), .MET_W(MET_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_frame(start_frame), .q_valid(q_valid),
    .q_index(q_index), .xI1_in(xI1_in), .xQ1_in(xQ1_in), .xI2_in(xI2_in),
    .xQ2_in(xQ2_in), .busy(busy), .det_valid(det_valid), .det_q(det_q),
    .det_bits(det_bits),
`ifdef XSEL_METRIC_OUT_EN
    .det_metric(det_metric),
`endif
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Nearest odd grid point: floor(x / 2.0) picks the pair, clamp to +-3
  function automatic int ref_level(input int x);
    int lv;
    lv = 2 * (x >>> 9) + 1;
    if (lv > 3)  lv = 3;
    if (lv < -3) lv = -3;
    return lv * 256;
  endfunction

  function automatic logic [1:0] ref_gray(input int x);
    case (ref_level(x))
      -768:    return 2'b00;
      -256:    return 2'b01;
      256:     return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic longint ref_metric(input int i);
    longint m = 0;
    for (int k = 0; k < 4; k++) begin
      int x = int'($signed(cx[i][k]));
      int e = x - ref_level(x);
      m += longint'(e) * longint'(e);
    end
    return m;
  endfunction

  task automatic drive(input bit sf, input bit v, input logic [QW-1:0] q,
                       input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] c, input logic [N-1:0] d);
    start_frame = sf; q_valid = v; q_index = q;
    xI1_in = a; xQ1_in = b; xI2_in = c; xQ2_in = d;
    @(posedge clk); #1;
    start_frame = 1'b0; q_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  task automatic send_cand(input int i, input bit sf);
    drive(sf, 1'b1, cq[i], cx[i][0], cx[i][1], cx[i][2], cx[i][3]);
  endtask

  function automatic logic [N-1:0] rand_comp();
    int lv = (int'($urandom_range(0, 3)) * 2 - 3) * 256;
    if ($urandom_range(0, 3) == 0) return N'($urandom);
    return N'(lv + int'($urandom_range(0, 300)) - 150);
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NUM_Q; i++) begin
      cq[i] = QW'($urandom);
      for (int k = 0; k < 4; k++) cx[i][k] = rand_comp();
    end
  endtask

  // Exact points (+1,-3,+3,-1), optionally offset by +0.25 on every component
  task automatic set_point(input int i, input bit offs);
    logic [N-1:0] o = offs ? 16'h0040 : 16'h0000;
    cx[i][0] = 16'h0100 + o; cx[i][1] = 16'hFD00 + o;
    cx[i][2] = 16'h0300 + o; cx[i][3] = 16'hFF00 + o;
  endtask

  task automatic run_frame(input string name, input int gap_max, input bit merge_sf, input bit extra);
    int     bi = 0;
    longint bm;
    int     lat;
    logic [7:0] eb;
    bm = ref_metric(0);
    for (int i = 1; i < NUM_Q; i++) if (ref_metric(i) < bm) begin bm = ref_metric(i); bi = i; end
    for (int k = 0; k < 4; k++) eb[7 - 2 * k -: 2] = ref_gray(int'($signed(cx[bi][k])));

    if (!merge_sf) drive(1'b1, 1'b0, '0, '0, '0, '0, '0);
    for (int i = 0; i < NUM_Q; i++) begin
      if (i > 0 && gap_max > 0) idle($urandom_range(0, gap_max));
      send_cand(i, merge_sf && i == 0);
      if (i == 0) check_val({name, ".busy"}, 64'(busy), 64'd1);
    end
    lat = 0;
    while (det_valid !== 1'b1 && lat < 12) begin
      if (extra && lat == 0) drive(1'b0, 1'b1, QW'($urandom), N'($urandom), '0, '0, '0);
      else                   idle(1);
      lat++;
    end
    check_val({name, ".latency"}, 64'(lat), 64'd4);
    check_val({name, ".det_q"}, 64'(det_q), 64'(cq[bi]));
    check_val({name, ".det_bits"}, 64'(det_bits), 64'(eb));
`ifdef XSEL_METRIC_OUT_EN
    check_val({name, ".det_metric"}, 64'(det_metric), 64'(bm));
`endif
    idle(1);
    check_val({name, ".pulse"}, 64'(det_valid), 64'd0);
    check_val({name, ".ovf"}, 64'(ovf), 64'(extra));
    check_val({name, ".idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bit seen_dv;
    rst_n = 1'b0; start_frame = 1'b0; q_valid = 1'b0; q_index = '0;
    xI1_in = '0; xQ1_in = '0; xI2_in = '0; xQ2_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.busy", 64'(busy), 64'd0);
    check_val("rst.det_valid", 64'(det_valid), 64'd0);
    check_val("rst.det_q", 64'(det_q), 64'd0);
    check_val("rst.det_bits", 64'(det_bits), 64'd0);
    check_val("rst.ovf", 64'(ovf), 64'd0);
`ifdef XSEL_METRIC_OUT_EN
    check_val("rst.det_metric", 64'(det_metric), 64'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Exact-point winner at q=5
    for (int i = 0; i < NUM_Q; i++) begin cq[i] = QW'(i); set_point(i, i != 5); end
    run_frame("exact", 0, 1'b0, 1'b0);
    check_val("exact.q5", 64'(det_q), 64'd5);
    check_val("exact.bits", 64'(det_bits), 64'b11_00_10_01);
`ifdef XSEL_METRIC_OUT_EN
    check_val("exact.metric0", 64'(det_metric), 64'd0);
`endif

    // Tie between q=3 and q=9
    for (int i = 0; i < NUM_Q; i++) begin cq[i] = QW'(i); set_point(i, i != 3 && i != 9); end
    run_frame("tie", 2, 1'b1, 1'b0);
    check_val("tie.q3", 64'(det_q), 64'd3);

    // Slicer boundaries on candidate 10; the rest sit far from the grid
    for (int i = 0; i < NUM_Q; i++) begin
      cq[i] = QW'(i);
      for (int k = 0; k < 4; k++) cx[i][k] = 16'h7000;
    end
    cx[10][0] = 16'h0000; cx[10][1] = 16'h0200; cx[10][2] = 16'hFE00; cx[10][3] = 16'hFDFF;
    run_frame("bound", 1, 1'b0, 1'b0);
    check_val("bound.bits", 64'(det_bits), 64'b11_10_01_00);
`ifdef XSEL_METRIC_OUT_EN
    check_val("bound.metric", 64'(det_metric), 64'h3FE01);
`endif

    // Back-to-back candidates plus a 17th during FLUSH
    fill_random();
    run_frame("b2b_ovf", 0, 1'b1, 1'b1);

    // Restart after 7 candidates, one of them exact
    for (int i = 0; i < 7; i++) begin cq[i] = QW'(i); set_point(i, i != 2); end
    drive(1'b1, 1'b0, '0, '0, '0, '0, '0);
    for (int i = 0; i < 7; i++) send_cand(i, 1'b0);
    for (int i = 0; i < NUM_Q; i++) begin cq[i] = QW'($urandom); set_point(i, 1'b1); end
    run_frame("restart", 1, 1'b1, 1'b0);
    check_val("restart.first", 64'(det_q), 64'(cq[0]));

    for (int f = 0; f < 6; f++) begin
      fill_random();
      run_frame("rand", int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end

    // Async reset mid-COLLECT, after a frame left non-zero results
    for (int i = 0; i < NUM_Q; i++) begin cq[i] = QW'(i); set_point(i, i != 5); end
    run_frame("pre_rst", 0, 1'b0, 1'b0);
    fill_random();
    drive(1'b1, 1'b0, '0, '0, '0, '0, '0);
    for (int i = 0; i < NUM_Q - 1; i++) send_cand(i, 1'b0);
    @(negedge clk); #2; rst_n = 1'b0; #1;
    check_val("arst.busy", 64'(busy), 64'd0);
    check_val("arst.det_q", 64'(det_q), 64'd0);
    check_val("arst.det_bits", 64'(det_bits), 64'd0);
    check_val("arst.det_valid", 64'(det_valid), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    seen_dv = 1'b0;
    send_cand(NUM_Q - 1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      if (det_valid === 1'b1) seen_dv = 1'b1;
      idle(1);
    end
    check_val("arst.no_det", 64'(seen_dv), 64'd0);
    check_val("arst.idle_ovf", 64'(ovf), 64'd0);
    fill_random();
    run_frame("post_rst", 2, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
